mastermind_game_ctrl: RTL and testbench

- Game-state writer for the Mastermind VGA display. Owns the 6-row guess matrix, current attempt index, input cursor and per-row scoring feedback; the VGA renderer reads these every pixel.
- Takes debounced single-cycle button pulses and a 12-bit secret code. Runs input, check, win and lose phases.
- Scores each submitted guess against the secret with standard exact/partial Mastermind rules.

---
 rtl/mastermind_game_ctrl_if.sv | 37 +++
 rtl/mastermind_game_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mastermind_game_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mastermind_game_ctrl_if.sv
// Button/secret inputs and game-state outputs of the Mastermind controller.
// The master side (stimulus/keypad logic) drives the buttons and secret;
// the slave side (the controller) drives the board and state outputs.
interface mastermind_game_ctrl_if #(
    parameter int ROWS = 6,
    parameter int COLS = 4
);
    logic                     start;
    logic                     btn_left;
    logic                     btn_right;
    logic                     btn_up;
    logic                     btn_down;
    logic                     btn_enter;
    logic [COLS*3-1:0]        secret;
    logic [ROWS*COLS*3-1:0]   matrix_flat;
    logic [ROWS*6-1:0]        feedback_flat;
    logic [2:0]               guess_num;
    logic [1:0]               cursor;
    logic                     q_Idle;
    logic                     q_Input;
    logic                     q_Check;
    logic                     q_Win;
    logic                     q_Lose;
    logic [COLS*3-1:0]        reveal;

    modport master (
        output start, btn_left, btn_right, btn_up, btn_down, btn_enter, secret,
        input  matrix_flat, feedback_flat, guess_num, cursor,
               q_Idle, q_Input, q_Check, q_Win, q_Lose, reveal
    );

    modport slave (
        input  start, btn_left, btn_right, btn_up, btn_down, btn_enter, secret,
        output matrix_flat, feedback_flat, guess_num, cursor,
               q_Idle, q_Input, q_Check, q_Win, q_Lose, reveal
    );
endinterface

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game-state writer: owns the guess matrix, attempt index, cursor
// and per-row exact/partial feedback read by the VGA renderer.
module mastermind_game_ctrl #(
    parameter int ROWS = 6,
    parameter int COLS = 4,
    parameter int NCOL = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    mastermind_game_ctrl_if.slave     bus
);
    localparam int RW = COLS * 3;

    // One-hot encoding so each q_ flag is a single state bit.
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b10000,
        ST_INPUT = 5'b01000,
        ST_CHECK = 5'b00100,
        ST_WIN   = 5'b00010,
        ST_LOSE  = 5'b00001
    } state_t;

    state_t                 r_state,     w_state_nxt;
    logic [ROWS*RW-1:0]     r_matrix,    w_matrix_nxt;
    logic [ROWS*6-1:0]      r_feedback,  w_feedback_nxt;
    logic [2:0]             r_guess_num, w_guess_num_nxt;
    logic [1:0]             r_cursor,    w_cursor_nxt;
    logic [RW-1:0]          r_secret,    w_secret_nxt;
    logic [RW-1:0]          r_reveal,    w_reveal_nxt;

    logic [RW-1:0]          w_row;
    logic [2:0]             w_slot, w_slot_up, w_slot_dn;
    logic                   w_row_full;
    logic [2:0]             w_exact, w_match, w_partial;
    logic [2:0]             w_cnt_g, w_cnt_s;

    // Select the active row and the slot under the cursor; precompute edits.
    always_comb begin
        w_row      = '0;
        w_slot     = '0;
        w_row_full = 1'b1;
        for (int unsigned r = 0; r < ROWS; r++)
            if (r_guess_num == 3'(r)) w_row = r_matrix[r*RW +: RW];
        for (int unsigned c = 0; c < COLS; c++) begin
            if (r_cursor == 2'(c)) w_slot = w_row[c*3 +: 3];
            if (w_row[c*3 +: 3] == 3'd0) w_row_full = 1'b0;
        end
        w_slot_up = (w_slot >= 3'(NCOL)) ? 3'd1 : w_slot + 3'd1;
        w_slot_dn = (w_slot <= 3'd1) ? 3'(NCOL) : w_slot - 3'd1;
    end

    // Score the active row: exact positions, and colour overlap via per-colour minimum counts.
    always_comb begin
        w_exact = '0;
        w_match = '0;
        w_cnt_g = '0;
        w_cnt_s = '0;
        for (int unsigned c = 0; c < COLS; c++)
            if (w_row[c*3 +: 3] == r_secret[c*3 +: 3]) w_exact = w_exact + 3'd1;
        for (int unsigned k = 1; k <= NCOL; k++) begin
            w_cnt_g = '0;
            w_cnt_s = '0;
            for (int unsigned c = 0; c < COLS; c++) begin
                if (w_row[c*3 +: 3] == 3'(k))    w_cnt_g = w_cnt_g + 3'd1;
                if (r_secret[c*3 +: 3] == 3'(k)) w_cnt_s = w_cnt_s + 3'd1;
            end
            w_match = w_match + ((w_cnt_g < w_cnt_s) ? w_cnt_g : w_cnt_s);
        end
        w_partial = w_match - w_exact;
    end

    // Next-state and datapath updates; start overrides every other input.
    always_comb begin
        w_state_nxt     = r_state;
        w_matrix_nxt    = r_matrix;
        w_feedback_nxt  = r_feedback;
        w_guess_num_nxt = r_guess_num;
        w_cursor_nxt    = r_cursor;
        w_secret_nxt    = r_secret;
        w_reveal_nxt    = r_reveal;
        if (bus.start) begin
            for (int unsigned c = 0; c < COLS; c++)
                w_secret_nxt[c*3 +: 3] =
                    (bus.secret[c*3 +: 3] == 3'd0 || bus.secret[c*3 +: 3] == 3'd7)
                    ? 3'd1 : bus.secret[c*3 +: 3];
            w_matrix_nxt    = '0;
            w_feedback_nxt  = '0;
            w_guess_num_nxt = '0;
            w_cursor_nxt    = '0;
            w_reveal_nxt    = '0;
            w_state_nxt     = ST_INPUT;
        end else begin
            unique case (r_state)
                ST_INPUT: begin
                    if (bus.btn_enter) begin
                        if (w_row_full) w_state_nxt = ST_CHECK;
                    end else if (bus.btn_up || bus.btn_down) begin
                        for (int unsigned r = 0; r < ROWS; r++)
                            for (int unsigned c = 0; c < COLS; c++)
                                if (r_guess_num == 3'(r) && r_cursor == 2'(c))
                                    w_matrix_nxt[(r*COLS + c)*3 +: 3] =
                                        bus.btn_up ? w_slot_up : w_slot_dn;
                    end else if (bus.btn_left) begin
                        w_cursor_nxt = r_cursor - 2'd1;
                    end else if (bus.btn_right) begin
                        w_cursor_nxt = r_cursor + 2'd1;
                    end
                end
                ST_CHECK: begin
                    for (int unsigned r = 0; r < ROWS; r++)
                        if (r_guess_num == 3'(r))
                            w_feedback_nxt[r*6 +: 6] = {w_partial, w_exact};
                    if (w_exact == 3'(COLS)) begin
                        w_state_nxt  = ST_WIN;
                        w_reveal_nxt = r_secret;
                    end else if (r_guess_num == 3'(ROWS - 1)) begin
                        w_state_nxt  = ST_LOSE;
                        w_reveal_nxt = r_secret;
                    end else begin
                        w_guess_num_nxt = r_guess_num + 3'd1;
                        w_cursor_nxt    = '0;
                        w_state_nxt     = ST_INPUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and game registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_matrix    <= '0;
            r_feedback  <= '0;
            r_guess_num <= '0;
            r_cursor    <= '0;
            r_secret    <= '0;
            r_reveal    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_matrix    <= w_matrix_nxt;
            r_feedback  <= w_feedback_nxt;
            r_guess_num <= w_guess_num_nxt;
            r_cursor    <= w_cursor_nxt;
            r_secret    <= w_secret_nxt;
            r_reveal    <= w_reveal_nxt;
        end
    end

    assign bus.matrix_flat   = r_matrix;
    assign bus.feedback_flat = r_feedback;
    assign bus.guess_num     = r_guess_num;
    assign bus.cursor        = r_cursor;
    assign bus.reveal        = r_reveal;
    assign bus.q_Idle        = (r_state == ST_IDLE);
    assign bus.q_Input       = (r_state == ST_INPUT);
    assign bus.q_Check       = (r_state == ST_CHECK);
    assign bus.q_Win         = (r_state == ST_WIN);
    assign bus.q_Lose        = (r_state == ST_LOSE);
endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Scoreboard bench for mastermind_game_ctrl: stimulus pushes the reference
// model's expected snapshot per clock edge; a monitor pops and compares.
module tb_mastermind_game_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mastermind_game_ctrl_if bus ();

    mastermind_game_ctrl #(.ROWS(6), .COLS(4), .NCOL(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [71:0] mat;
        logic [35:0] fb;
        logic [2:0]  g;
        logic [1:0]  cur;
        logic [4:0]  q;     // {Idle, Input, Check, Win, Lose}
        logic [11:0] rev;
    } snap_t;

    localparam bit [5:0] B_START = 6'd1,  B_LEFT = 6'd2,  B_RIGHT = 6'd4,
                         B_UP    = 6'd8,  B_DOWN = 6'd16, B_ENTER = 6'd32;

    snap_t       exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] g_sec = 12'h0;

    // Reference model: game state as plain integers.
    int m_st;           // 0 idle, 1 input, 2 check, 3 win, 4 lose
    int m_board[6][4];
    int m_ex[6];
    int m_pa[6];
    int m_g, m_cur;
    int m_sec[4];

    function automatic void m_reset();
        m_st = 0; m_g = 0; m_cur = 0;
        for (int r = 0; r < 6; r++) begin
            m_ex[r] = 0; m_pa[r] = 0;
            for (int c = 0; c < 4; c++) m_board[r][c] = 0;
        end
        for (int c = 0; c < 4; c++) m_sec[c] = 0;
    endfunction

    // Classic peg marking: pair exact matches first, then pair leftovers by colour.
    function automatic void m_score(output int ex, output int pa);
        bit gu[4];
        bit su[4];
        ex = 0; pa = 0;
        for (int i = 0; i < 4; i++) begin gu[i] = 0; su[i] = 0; end
        for (int i = 0; i < 4; i++)
            if (m_board[m_g][i] == m_sec[i]) begin ex++; gu[i] = 1; su[i] = 1; end
        for (int i = 0; i < 4; i++) begin
            if (gu[i]) continue;
            for (int j = 0; j < 4; j++)
                if (!su[j] && m_board[m_g][i] == m_sec[j]) begin su[j] = 1; pa++; break; end
        end
    endfunction

    function automatic void m_step(bit [5:0] b, logic [11:0] sec);
        int ex, pa;
        bit full;
        logic [2:0] s;
        if (b[0]) begin
            m_reset();
            for (int c = 0; c < 4; c++) begin
                s = sec[c*3 +: 3];
                m_sec[c] = (s == 0 || s == 7) ? 1 : int'(s);
            end
            m_st = 1;
            return;
        end
        case (m_st)
            1: begin
                full = 1;
                for (int c = 0; c < 4; c++) if (m_board[m_g][c] == 0) full = 0;
                if (b[5]) begin
                    if (full) m_st = 2;
                end else if (b[3]) m_board[m_g][m_cur] = (m_board[m_g][m_cur] == 6) ? 1 : m_board[m_g][m_cur] + 1;
                else if (b[4]) m_board[m_g][m_cur] = (m_board[m_g][m_cur] <= 1) ? 6 : m_board[m_g][m_cur] - 1;
                else if (b[1]) m_cur = (m_cur + 3) % 4;
                else if (b[2]) m_cur = (m_cur + 1) % 4;
            end
            2: begin
                m_score(ex, pa);
                m_ex[m_g] = ex; m_pa[m_g] = pa;
                if (ex == 4) m_st = 3;
                else if (m_g == 5) m_st = 4;
                else begin m_g++; m_cur = 0; m_st = 1; end
            end
            default: ;
        endcase
    endfunction

    function automatic snap_t m_snap();
        snap_t e;
        e = '0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) e.mat[(r*4 + c)*3 +: 3] = 3'(m_board[r][c]);
            e.fb[r*6 +: 6] = {3'(m_pa[r]), 3'(m_ex[r])};
        end
        e.g   = 3'(m_g);
        e.cur = 2'(m_cur);
        e.q   = 5'b10000 >> m_st;
        if (m_st == 3 || m_st == 4)
            for (int c = 0; c < 4; c++) e.rev[c*3 +: 3] = 3'(m_sec[c]);
        return e;
    endfunction

    function automatic snap_t dut_snap();
        snap_t a;
        a.mat = bus.matrix_flat;
        a.fb  = bus.feedback_flat;
        a.g   = bus.guess_num;
        a.cur = bus.cursor;
        a.q   = {bus.q_Idle, bus.q_Input, bus.q_Check, bus.q_Win, bus.q_Lose};
        a.rev = bus.reveal;
        return a;
    endfunction

    task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_snap(string tag, snap_t a, snap_t e);
        chk({tag, "matrix"},   72'(a.mat), 72'(e.mat));
        chk({tag, "feedback"}, 72'(a.fb),  72'(e.fb));
        chk({tag, "guess_num"},72'(a.g),   72'(e.g));
        chk({tag, "cursor"},   72'(a.cur), 72'(e.cur));
        chk({tag, "q_flags"},  72'(a.q),   72'(e.q));
        chk({tag, "reveal"},   72'(a.rev), 72'(e.rev));
    endtask

    // One clock of stimulus; pushes what the DUT must show after the next rising edge.
    task automatic cycle(bit rst, bit [5:0] b, logic [11:0] sec);
        @(negedge clk);
        if (rst && !reset) begin
            reset = 1'b1;
            #1;
            m_reset();
            cmp_snap("async_rst_", dut_snap(), m_snap());
        end
        reset         = rst;
        bus.start     = b[0];
        bus.btn_left  = b[1];
        bus.btn_right = b[2];
        bus.btn_up    = b[3];
        bus.btn_down  = b[4];
        bus.btn_enter = b[5];
        bus.secret    = sec;
        if (rst) m_reset();
        else     m_step(b, sec);
        exp_q.push_back(m_snap());
    endtask

    task automatic press(bit [5:0] b);
        cycle(1'b0, b, g_sec);
    endtask

    task automatic idle(int n);
        repeat (n) cycle(1'b0, 6'd0, g_sec);
    endtask

    task automatic start_game(logic [11:0] s);
        g_sec = s;
        press(B_START);
        g_sec = 12'($urandom);   // later secret changes must not matter
    endtask

    task automatic set_row(int c0, int c1, int c2, int c3);
        int v[4] = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            repeat (v[i]) press(B_UP);
            press(B_RIGHT);
        end
    endtask

    // Monitor: compare every DUT snapshot just after the rising edge.
    initial begin
        forever begin
            snap_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp_snap("", dut_snap(), e);
            end
        end
    end

    initial begin
        int t;
        int r;
        bit [5:0] b;
        bus.start = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_enter = 0; bus.secret = '0;
        m_reset();

        // Reset and idle: buttons have no effect
        repeat (3) cycle(1'b1, 6'd0, 12'h0);
        idle(2);
        press(B_UP); press(B_UP); press(B_ENTER);

        // Colour edits and cursor wrap
        start_game(12'h8D1);
        repeat (7) press(B_UP);
        press(B_RIGHT); press(B_DOWN);
        press(B_LEFT);  press(B_LEFT);

        // Incomplete submit is ignored
        start_game(12'h8D1);
        for (int i = 0; i < 3; i++) begin press(B_UP); press(B_RIGHT); end
        press(B_ENTER);
        idle(2);

        // Basic scoring: secret (1,2,3,4), guess (2,1,3,5)
        start_game(12'h8D1);
        set_row(2, 1, 3, 5);
        press(B_ENTER);
        idle(2);

        // Duplicates, then win
        start_game(12'h489);
        set_row(1, 2, 1, 1);
        press(B_ENTER);
        idle(1);
        set_row(1, 1, 2, 2);
        press(B_ENTER);
        idle(1);
        press(B_UP); press(B_LEFT); press(B_ENTER);

        // Six misses -> lose, then restart with sanitised all-zero secret
        start_game(12'h8D1);
        repeat (6) begin set_row(5, 5, 5, 5); press(B_ENTER); idle(1); end
        press(B_DOWN); press(B_ENTER);
        start_game(12'h000);
        press(B_UP); press(B_UP);
        cycle(1'b1, 6'd0, g_sec);
        cycle(1'b1, B_UP, g_sec);
        idle(1);
        press(B_UP);

        // Start mid-CHECK has priority
        start_game(12'hFFF);
        set_row(1, 1, 1, 1);
        press(B_ENTER);
        start_game(12'h123);
        idle(1);

        // Randomised play, including simultaneous buttons
        start_game(12'($urandom));
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 199);
            b = 6'd0;
            if (i == 2000) begin
                cycle(1'b1, 6'd0, g_sec);
                b = B_START;
            end else if (r < 1) b = B_START;
            else if (r < 130) b = 6'(1 << $urandom_range(1, 5));
            else if (r < 150) b = 6'($urandom) & 6'b111110;
            g_sec = 12'($urandom);
            press(b);
        end

        // Drain the scoreboard with a bounded wait
        t = 0;
        while (exp_q.size() > 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain actual=%0d expected=0 pending snapshots", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
